// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and frame-bit constants for the UART receive
//               controller (FSM state encoding, sticky error record, helpers).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    PUSH  = 2'd2
  } rx_state_e;

  localparam int START_BIT = 0;
  localparam int DATA_LSB  = 1;
  localparam int DATA_MSB  = 8;
  localparam int PAR_BIT   = 9;
  localparam int STOP_BIT  = 10;

  typedef struct packed {
    logic frame;
    logic parity;
    logic overrun;
  } rx_err_t;

  // Framing is bad when the start bit is not low or the stop bit is not high.
  function automatic logic frame_error(input logic [10:0] f);
    return f[START_BIT] | ~f[STOP_BIT];
  endfunction

  // XOR over data+parity is 1 for odd total ones; mismatch against the mode.
  function automatic logic parity_error(input logic [10:0] f, input logic en,
                                        input logic odd);
    return en & ((^f[PAR_BIT:DATA_LSB]) != odd);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl_if
// Description : Bundle between the SIPO/core side and the receive controller.
//               master = frame source and core, slave = uart_rx_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_ctrl_if #(
  parameter int FIFO_DEPTH = 8
) ();
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [10:0]      frame_in;
  logic             frame_done;
  logic             cfg_parity_en;
  logic             cfg_parity_odd;
  logic             rd_en;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic [CNT_W-1:0] fifo_count;
  logic             err_frame;
  logic             err_parity;
  logic             err_overrun;
  logic             err_clr;
  logic             rx_timeout;
  logic             irq;

  modport master (
    output frame_in, frame_done, cfg_parity_en, cfg_parity_odd, rd_en, err_clr,
    input  rd_data, rd_valid, fifo_count, err_frame, err_parity, err_overrun,
           rx_timeout, irq
  );

  modport slave (
    input  frame_in, frame_done, cfg_parity_en, cfg_parity_odd, rd_en, err_clr,
    output rd_data, rd_valid, fifo_count, err_frame, err_parity, err_overrun,
           rx_timeout, irq
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered head output. The occupancy
//               count is the only source of full/empty; pointers wrap freely.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       push,
  input  wire logic [WIDTH-1:0]           wdata,
  input  wire logic                       pop,
  output logic      [WIDTH-1:0]           rdata,
  output logic                            valid,
  output logic      [$clog2(DEPTH):0]     count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    rptr_nxt;
  logic             pop_ok;
  logic             push_ok;
  logic             is_full;
  logic             is_empty;

  // Qualify requests: pop needs data, push needs room unless a pop frees a slot.
  always_comb begin
    is_empty = (count == '0);
    is_full  = (count == CNT_W'(DEPTH));
    pop_ok   = pop & ~is_empty;
    push_ok  = push & (~is_full | pop_ok);
    rptr_nxt = rptr + AW'(1);
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers, count and the registered head byte (holds when nothing to show).
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rdata <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr_nxt;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (is_empty && push_ok) begin
        rdata <= wdata;
      end else if (pop_ok) begin
        if (count >= CNT_W'(2)) rdata <= mem[rptr_nxt];
        else if (push_ok)       rdata <= wdata;
      end
    end
  end

  assign valid = ~is_empty;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : UART receive controller behind the SIPO deserializer. Edge
//               detects frame_done, checks start/stop/parity, buffers good
//               bytes in a FIFO, keeps sticky error flags and drives irq.
//               Optional idle timeout enabled by defining UART_RX_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int IRQ_THRESH  = 4,
  parameter int TIMEOUT_CYC = 160
) (
  input wire logic  clk,
  input wire logic  reset,
  uart_rx_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             fd_q;
  logic             pending;
  rx_state_e        state;
  logic [10:0]      frame_r;
  logic             ferr_r;
  logic             perr_r;
  rx_err_t          err;
  rx_err_t          err_set;
  logic             rise;
  logic             consume;
  logic             lost;
  logic             pop;
  logic             push;
  logic             full;
  logic             drop_ovr;
  logic             rx_to;
  logic [7:0]       fifo_rdata;
  logic             fifo_valid;
  logic [CNT_W-1:0] fifo_cnt;

  // Edge detect, push/drop decisions and error set terms.
  always_comb begin
    rise     = bus.frame_done & ~fd_q;
    consume  = (state == IDLE) & pending;
    lost     = rise & pending & ~consume;
    pop      = bus.rd_en & fifo_valid;
    full     = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    push     = (state == PUSH) & ~ferr_r & (~full | bus.rd_en);
    drop_ovr = (state == PUSH) & ~ferr_r & full & ~bus.rd_en;
    err_set.frame   = (state == PUSH) & ferr_r;
    err_set.parity  = (state == PUSH) & ~ferr_r & perr_r;
    err_set.overrun = drop_ovr | lost;
  end

  // Frame FSM with edge register and pending latch; fd_q resets high so a
  // level held across reset is not seen as a fresh frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      fd_q    <= 1'b1;
      pending <= 1'b0;
      state   <= IDLE;
      frame_r <= '0;
      ferr_r  <= 1'b0;
      perr_r  <= 1'b0;
    end else begin
      fd_q    <= bus.frame_done;
      pending <= rise | (pending & ~consume);
      case (state)
        IDLE: begin
          if (pending) begin
            frame_r <= bus.frame_in;
            state   <= CHECK;
          end
        end
        CHECK: begin
          ferr_r <= frame_error(frame_r);
          perr_r <= parity_error(frame_r, bus.cfg_parity_en, bus.cfg_parity_odd);
          state  <= PUSH;
        end
        PUSH:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky errors; a new set beats err_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) err <= '0;
    else       err <= rx_err_t'(err_set | (err & ~{3{bus.err_clr}}));
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (frame_r[DATA_MSB:DATA_LSB]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .valid (fifo_valid),
    .count (fifo_cnt)
  );

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
  logic          to_inc;
  logic          to_clr;

  // Count only while bytes sit unread with the receiver quiet.
  always_comb begin
    to_clr = push | pop | ~fifo_valid;
    to_inc = ~to_clr & (state == IDLE) & ~pending;
  end

  // Idle counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      rx_to  <= 1'b0;
    end else begin
      if (to_clr)                                  to_cnt <= '0;
      else if (to_inc && to_cnt != TW'(TIMEOUT_CYC)) to_cnt <= to_cnt + TW'(1);
      if (to_inc && to_cnt == TW'(TIMEOUT_CYC - 1)) rx_to <= 1'b1;
      else if (pop | bus.err_clr | ~fifo_valid)       rx_to <= 1'b0;
    end
  end
`else
  assign rx_to = 1'b0;
`endif

  assign bus.rd_data     = fifo_rdata;
  assign bus.rd_valid    = fifo_valid;
  assign bus.fifo_count  = fifo_cnt;
  assign bus.err_frame   = err.frame;
  assign bus.err_parity  = err.parity;
  assign bus.err_overrun = err.overrun;
  assign bus.rx_timeout  = rx_to;
  assign bus.irq         = (fifo_cnt >= CNT_W'(IRQ_THRESH)) | (|err) | rx_to;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Directed self-checking bench for uart_rx_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;
  logic clk;
  logic reset;
  int   n_asserts;
  int   n_fail;

  uart_rx_ctrl_if #(.FIFO_DEPTH(8)) bus ();

  uart_rx_ctrl #(
    .FIFO_DEPTH  (8),
    .IRQ_THRESH  (4),
    .TIMEOUT_CYC (160)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic par,
                                     input logic stop, input logic start);
    return {stop, par, d, start};
  endfunction

  // One-cycle frame_done pulse, returns just after the push edge (E+3).
  task automatic send(input logic [10:0] f);
    bus.frame_in   = f;
    bus.frame_done = 1'b1;
    tick(1);
    bus.frame_done = 1'b0;
    tick(3);
  endtask

  task automatic pop1();
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
  endtask

  task automatic clr_errs();
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
  endtask

  function automatic logic [2:0] errs();
    return {bus.err_frame, bus.err_parity, bus.err_overrun};
  endfunction

  logic [7:0] exp_q [8];

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    reset              = 1'b1;
    bus.frame_in       = '0;
    bus.frame_done     = 1'b0;
    bus.cfg_parity_en  = 1'b1;
    bus.cfg_parity_odd = 1'b0;
    bus.rd_en          = 1'b0;
    bus.err_clr        = 1'b0;
    tick(3);
    check("rst_count", 32'(bus.fifo_count), 0);
    check("rst_valid", 32'(bus.rd_valid), 0);
    check("rst_data", 32'(bus.rd_data), 0);
    check("rst_errs", 32'(errs()), 0);
    check("rst_to", 32'(bus.rx_timeout), 0);
    check("rst_irq", 32'(bus.irq), 0);
    reset = 1'b0;
    tick(1);

    // Good even-parity frame 0xA5 with latency check.
    bus.frame_in   = mk(8'hA5, 1'b0, 1'b1, 1'b0);
    bus.frame_done = 1'b1;
    tick(1);
    bus.frame_done = 1'b0;
    tick(2);
    check("t1_valid_e2", 32'(bus.rd_valid), 0);
    tick(1);
    check("t1_valid_e3", 32'(bus.rd_valid), 1);
    check("t1_data", 32'(bus.rd_data), 32'hA5);
    check("t1_count", 32'(bus.fifo_count), 1);
    check("t1_errs", 32'(errs()), 0);
    check("t1_irq", 32'(bus.irq), 0);
    pop1();
    check("t1_pop_count", 32'(bus.fifo_count), 0);
    check("t1_pop_valid", 32'(bus.rd_valid), 0);
    check("t1_pop_hold", 32'(bus.rd_data), 32'hA5);
    pop1();
    check("t1_empty_pop", 32'(bus.fifo_count), 0);

    // Parity flipped: byte kept, parity error raised then cleared.
    send(mk(8'hA5, 1'b1, 1'b1, 1'b0));
    check("t2_count", 32'(bus.fifo_count), 1);
    check("t2_data", 32'(bus.rd_data), 32'hA5);
    check("t2_errs", 32'(errs()), 3'b010);
    check("t2_irq", 32'(bus.irq), 1);
    clr_errs();
    check("t2_clr_errs", 32'(errs()), 0);
    check("t2_clr_irq", 32'(bus.irq), 0);
    pop1();

    // Stop bit low: dropped with framing error.
    send(mk(8'h3C, 1'b0, 1'b0, 1'b0));
    check("t3_count", 32'(bus.fifo_count), 0);
    check("t3_valid", 32'(bus.rd_valid), 0);
    check("t3_errs", 32'(errs()), 3'b100);
    check("t3_irq", 32'(bus.irq), 1);
    clr_errs();
    check("t3_clr", 32'(errs()), 0);

    // Fill past depth, irq threshold, overrun, full+push+pop.
    bus.cfg_parity_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send(mk(8'(i * 17 + 1), 1'b0, 1'b1, 1'b0));
      if (i == 2) check("t4_irq_below", 32'(bus.irq), 0);
      if (i == 3) check("t4_irq_at", 32'(bus.irq), 1);
      if (i == 7) begin
        check("t4_full_count", 32'(bus.fifo_count), 8);
        check("t4_full_ovr", 32'(bus.err_overrun), 0);
        check("t4_full_head", 32'(bus.rd_data), 32'h01);
      end
    end
    check("t4_drop_count", 32'(bus.fifo_count), 8);
    check("t4_drop_ovr", 32'(bus.err_overrun), 1);
    clr_errs();
    check("t4_ovr_clr", 32'(bus.err_overrun), 0);
    bus.frame_in   = mk(8'hEE, 1'b0, 1'b1, 1'b0);
    bus.frame_done = 1'b1;
    tick(1);
    bus.frame_done = 1'b0;
    tick(2);
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    check("t4_pp_count", 32'(bus.fifo_count), 8);
    check("t4_pp_head", 32'(bus.rd_data), 32'h12);
    check("t4_pp_ovr", 32'(bus.err_overrun), 0);
    exp_q = '{8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78, 8'hEE};
    bus.rd_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t4_drain%0d", k), 32'(bus.rd_data), 32'(exp_q[k]));
      tick(1);
    end
    bus.rd_en = 1'b0;
    check("t4_drained", 32'(bus.fifo_count), 0);

    // Rising edges every other cycle: the fourth lands while one is pending.
    bus.frame_in = mk(8'h5A, 1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 4; j++) begin
      bus.frame_done = 1'b1;
      tick(1);
      bus.frame_done = 1'b0;
      tick(1);
    end
    tick(6);
    check("t_lost_count", 32'(bus.fifo_count), 3);
    check("t_lost_ovr", 32'(bus.err_overrun), 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t_lost_rst_count", 32'(bus.fifo_count), 0);
    check("t_lost_rst_errs", 32'(errs()), 0);
    tick(1);

    // frame_done held high with reset in the middle of the hold.
    bus.frame_in   = mk(8'h77, 1'b0, 1'b1, 1'b0);
    bus.frame_done = 1'b1;
    tick(5);
    check("t5_one_push", 32'(bus.fifo_count), 1);
    check("t5_data", 32'(bus.rd_data), 32'h77);
    tick(3);
    check("t5_still_one", 32'(bus.fifo_count), 1);
    reset = 1'b1;
    tick(2);
    check("t5_rst_count", 32'(bus.fifo_count), 0);
    check("t5_rst_data", 32'(bus.rd_data), 0);
    check("t5_rst_irq", 32'(bus.irq), 0);
    reset = 1'b0;
    tick(6);
    bus.frame_done = 1'b0;
    tick(6);
    check("t5_after_count", 32'(bus.fifo_count), 0);
    check("t5_after_valid", 32'(bus.rd_valid), 0);

    // Idle timeout with one byte waiting.
    send(mk(8'hC3, 1'b0, 1'b1, 1'b0));
    check("t6_count", 32'(bus.fifo_count), 1);
`ifdef UART_RX_TIMEOUT_EN
    tick(150);
    check("t6_to_early", 32'(bus.rx_timeout), 0);
    tick(20);
    check("t6_to_set", 32'(bus.rx_timeout), 1);
    check("t6_irq_set", 32'(bus.irq), 1);
    pop1();
    check("t6_to_clr", 32'(bus.rx_timeout), 0);
    check("t6_irq_clr", 32'(bus.irq), 0);
`else
    tick(170);
    check("t6_to_off", 32'(bus.rx_timeout), 0);
    check("t6_irq_off", 32'(bus.irq), 0);
    pop1();
    check("t6_pop_count", 32'(bus.fifo_count), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
